bubble_sorter_param: RTL and testbench
======================================

Name: bubble_sorter_param

Overview:
Parametrised serial bubble sorter: accepts N signed or unsigned W-bit elements in one valid/ready beat, sorts ascending with one compare-swap per clock, returns the sorted vector in one valid/ready beat. Generalises the fixed 4-element 4-bit top_sorter to arbitrary N/W, adds runtime-independent signedness, flow control, a swap counter and optional early termination. Sits between an upstream producer and downstream consumer in the sorting datapath.

Parameters:
N, 4, number of elements (N >= 2)
W, 4, element width in bits
SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream vector valid
in_ready  output  1  sorter can accept a vector
in_data  input  N*W  element k at bits [k*W +: W]
out_valid  output  1  sorted vector available
out_ready  input  1  downstream accepts output
out_data  output  N*W  sorted ascending; element 0 (LSBs) smallest
swap_cnt  output  SWAP_W  swaps performed for the current vector; SWAP_W = $clog2(N*(N-1)/2+1)
busy  output  1  high in SORT state

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE, in_ready=1, out_valid=0, busy=0, swap_cnt=0, out_data=0, pass/index counters 0. Reset has priority over every other event, including mid-sort and mid-output; any in-flight vector is discarded.
- States: IDLE, SORT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: load in_data into element registers, clear swap_cnt, pass=0, idx=0, go SORT. Otherwise stay.
- SORT: in_ready=0, busy=1. Each cycle compare elem[idx] and elem[idx+1] (signed if SIGNED=1); swap only if elem[idx] > elem[idx+1] (strict; equal elements never swapped, so sort is stable); increment swap_cnt on swap. idx counts 0..N-2; at idx=N-2, idx wraps to 0 and pass increments. After pass N-2 completes (N-1 passes, (N-1)^2 compares), go DONE.
- Latency: accept edge at cycle k -> out_valid high after edge k+1+(N-1)^2 (N=4: 10 cycles).
- DONE: out_valid=1, out_data = element registers, swap_cnt held; both stable while out_ready=0. On out_valid&&out_ready go IDLE; out_valid drops next cycle. in_ready stays 0 in DONE (no overlap; one vector in flight).
- out_data and swap_cnt retain last values in IDLE until the next load.
- in_valid in SORT/DONE is ignored; upstream must hold it.
- N=2: one pass of one compare, latency 2.

Optional Feature:
SORTER_EARLY_EXIT_EN
- Defined: a per-pass swap flag is kept; if a pass completes with no swap, go DONE immediately after that pass. Already sorted input finishes after N-1 compares (N=4: out_valid 4 cycles after accept). Output data and swap_cnt identical to non-EN build.
- Undefined: fixed (N-1)^2 compare cycles for every vector; swap-flag logic absent.

Decomposition:
- Package sorter_pkg: state enum (IDLE/SORT/DONE), function swap_w(N) for SWAP_W, signed/unsigned compare function parametrised by W and SIGNED.
- One sub-module natural: sorter_cmp_swap (combinational compare-exchange of two W-bit elements, outputs lo, hi, swapped); instantiated once and muxed on idx.

Test Plan:
- N=4 W=4 SIGNED=1: in_data=16'h1CE6 (6,-2,-4,1) -> out_data=16'h61EC (-4,-2,1,6), swap_cnt=4, out_valid 10 cycles after accept (both builds).
- N=4 W=4 SIGNED=0: in_data=16'h1CE6 (6,14,12,1) -> out_data=16'hEC61, swap_cnt=4.
- Sorted input 16'h4321 (1,2,3,4) -> out_data=16'h4321, swap_cnt=0; out_valid after 4 cycles with SORTER_EARLY_EXIT_EN, 10 without.
- Reverse input 16'h1357 (7,5,3,1) -> out_data=16'h7531, swap_cnt=6; hold out_ready=0 for 5 cycles: out_data/swap_cnt stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle.
- Reset mid-sort: rst_n low for 1 edge at 3rd SORT cycle -> next cycle IDLE, in_ready=1, out_valid=0, swap_cnt=0; a new vector 16'h1CE6 then sorts correctly.
- N=8 W=8 SIGNED=1, random vectors incl. duplicates and 8'h80/8'h7F -> out_data matches reference model, swap_cnt equals inversion count, back-to-back vectors with out_ready always 1.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the serial bubble sorter.
package sorter_pkg;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

  // Widest element the compare helper handles.
  localparam int CMP_MAX_W = 64;

  // Width of a counter that can hold the worst-case swap count N*(N-1)/2.
  function automatic int swap_w(input int n);
    return $clog2(n * (n - 1) / 2 + 1);
  endfunction

  // a > b on w-bit elements. For signed data the sign bit is flipped on both
  // operands, turning two's complement into offset binary so a plain unsigned
  // compare gives the signed ordering.
  function automatic logic elem_gt(input logic [CMP_MAX_W-1:0] a,
                                   input logic [CMP_MAX_W-1:0] b,
                                   input int w, input bit sgn);
    logic [CMP_MAX_W-1:0] msk;
    msk = sgn ? (CMP_MAX_W'(1) << (w - 1)) : '0;
    return (a ^ msk) > (b ^ msk);
  endfunction

endpackage

// File: rtl/sorter_cmp_swap.sv
// Combinational compare-exchange of two W-bit elements.
module sorter_cmp_swap
  import sorter_pkg::*;
#(
  parameter int W      = 4,
  parameter int SIGNED = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o,
  output logic         swapped_o
);

  // Strict greater-than keeps equal elements in place, so the sort is stable.
  assign swapped_o = elem_gt(CMP_MAX_W'(a_i), CMP_MAX_W'(b_i), W, SIGNED != 0);
  assign lo_o      = swapped_o ? b_i : a_i;
  assign hi_o      = swapped_o ? a_i : b_i;

endmodule

// File: rtl/bubble_sorter_param.sv
// Serial bubble sorter: one vector in, one compare-swap per clock, one sorted
// vector out. Define SORTER_EARLY_EXIT_EN to finish after the first pass that
// performs no swap.
module bubble_sorter_param
  import sorter_pkg::*;
#(
  parameter int N      = 4,
  parameter int W      = 4,
  parameter int SIGNED = 1,
  localparam int SWAP_W = swap_w(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*W-1:0]    out_data,
  output logic [SWAP_W-1:0] swap_cnt,
  output logic              busy
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 2);

  state_e                    state_q;
  logic [N-1:0][W-1:0]       elem_q;
  logic [IDX_W-1:0]          idx_q, pass_q, idx_p1;
  logic [SWAP_W-1:0]         swap_cnt_q;
  logic [N*W-1:0]            out_data_q;
  logic                      in_ready_q, out_valid_q, busy_q;
  logic [W-1:0]              lo, hi;
  logic                      swapped, stop_early;

  assign idx_p1 = idx_q + IDX_W'(1);

  sorter_cmp_swap #(.W(W), .SIGNED(SIGNED)) u_cmp (
    .a_i      (elem_q[idx_q]),
    .b_i      (elem_q[idx_p1]),
    .lo_o     (lo),
    .hi_o     (hi),
    .swapped_o(swapped)
  );

`ifdef SORTER_EARLY_EXIT_EN
  logic pass_swap_q;

  // A pass that ends without any swap means the vector is already sorted.
  always_comb stop_early = !pass_swap_q && !swapped;

  // Track whether the current pass has swapped anything yet.
  always_ff @(posedge clk) begin
    if (!rst_n)                                      pass_swap_q <= 1'b0;
    else if (state_q != SORT || idx_q == LAST_IDX)   pass_swap_q <= 1'b0;
    else                                             pass_swap_q <= pass_swap_q | swapped;
  end
`else
  assign stop_early = 1'b0;
`endif

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      swap_cnt_q  <= '0;
      out_data_q  <= '0;
      elem_q      <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready_q) begin
          elem_q     <= in_data;
          swap_cnt_q <= '0;
          idx_q      <= '0;
          pass_q     <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          state_q    <= SORT;
        end
        SORT: begin
          if (swapped) begin
            elem_q[idx_q]  <= lo;
            elem_q[idx_p1] <= hi;
            swap_cnt_q     <= swap_cnt_q + SWAP_W'(1);
          end
          if (idx_q == LAST_IDX) begin
            idx_q  <= '0;
            pass_q <= pass_q + IDX_W'(1);
            if (pass_q == LAST_IDX || stop_early) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end else begin
            idx_q <= idx_p1;
          end
        end
        DONE: begin
          // First DONE cycle captures the final element registers.
          if (!out_valid_q) begin
            out_data_q  <= elem_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign swap_cnt  = swap_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bubble_sorter_param.sv
// Directed bench for the bubble sorter: N=4 signed and unsigned instances
// sharing stimulus, plus an N=8 W=8 signed instance against a reference model.
module tb_bubble_sorter_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // N=4 instances share stimulus
  logic        in_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [15:0] in_data4 = '0;
  logic        in_ready_s, out_valid_s, busy_s, in_ready_u, out_valid_u, busy_u;
  logic [15:0] out_data_s, out_data_u;
  logic [2:0]  swap_s, swap_u;

  bubble_sorter_param #(.N(4), .W(4), .SIGNED(1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready_s),
    .in_data(in_data4), .out_valid(out_valid_s), .out_ready(out_ready4),
    .out_data(out_data_s), .swap_cnt(swap_s), .busy(busy_s));

  bubble_sorter_param #(.N(4), .W(4), .SIGNED(0)) u_u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready_u),
    .in_data(in_data4), .out_valid(out_valid_u), .out_ready(out_ready4),
    .out_data(out_data_u), .swap_cnt(swap_u), .busy(busy_u));

  // N=8 W=8 signed instance
  logic        in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic [63:0] in_data8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [63:0] out_data8;
  logic [4:0]  swap8;

  bubble_sorter_param #(.N(8), .W(8), .SIGNED(1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .swap_cnt(swap8), .busy(busy8));

`ifdef SORTER_EARLY_EXIT_EN
  localparam int LAT_SORTED = 4;
`else
  localparam int LAT_SORTED = 10;
`endif

  task automatic push4(input logic [15:0] d);
    int t;
    @(negedge clk);
    in_data4  = d;
    in_valid4 = 1'b1;
    t = 0;
    while (!in_ready_s && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("push4_timeout", 64'(in_ready_s), 64'd1);
    @(posedge clk);
    #1 in_valid4 = 1'b0;
  endtask

  task automatic wait_out4(output int lat);
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!out_valid_s && lat < 200);
    if (!out_valid_s) chk("out4_timeout", 64'(out_valid_s), 64'd1);
  endtask

  task automatic pop4();
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1 out_ready4 = 1'b0;
    chk("pop_ovalid", 64'(out_valid_s), 64'd0);
    chk("pop_iready", 64'(in_ready_s), 64'd1);
  endtask

  // Reference model for the signed N=8 W=8 case
  task automatic ref8(input logic [63:0] d, output logic [63:0] s, output int inv);
    int a[8];
    int tmp;
    inv = 0;
    for (int k = 0; k < 8; k++) a[k] = int'($signed(d[k*8 +: 8]));
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (a[i] > a[j]) inv++;
    for (int i = 1; i < 8; i++)
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        tmp = a[j]; a[j] = a[j-1]; a[j-1] = tmp;
      end
    for (int k = 0; k < 8; k++) s[k*8 +: 8] = a[k][7:0];
  endtask

  task automatic run8(input logic [63:0] d, input logic [63:0] exp_d, input int exp_inv);
    int t, lat;
    @(negedge clk);
    in_data8  = d;
    in_valid8 = 1'b1;
    t = 0;
    while (!in_ready8 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("push8_timeout", 64'(in_ready8), 64'd1);
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!out_valid8 && lat < 200);
    chk("n8_valid", 64'(out_valid8), 64'd1);
    chk("n8_data", out_data8, exp_d);
    chk("n8_swaps", 64'(swap8), 64'(exp_inv));
`ifndef SORTER_EARLY_EXIT_EN
    chk("n8_latency", 64'(lat), 64'd50);
`endif
  endtask

  initial begin
    int lat;
    logic [63:0] v, s;
    int inv;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iready", 64'(in_ready_s), 64'd1);
    chk("rst_ovalid", 64'(out_valid_s), 64'd0);
    chk("rst_busy", 64'(busy_s), 64'd0);
    chk("rst_swap", 64'(swap_s), 64'd0);
    chk("rst_data", 64'(out_data_s), 64'd0);
    rst_n = 1'b1;

    // mixed-sign vector, both signednesses
    push4(16'h1CE6);
    chk("sort_busy", 64'(busy_s), 64'd1);
    chk("sort_iready", 64'(in_ready_s), 64'd0);
    wait_out4(lat);
    chk("s_lat", 64'(lat), 64'd10);
    chk("s_data", 64'(out_data_s), 64'h61EC);
    chk("s_swap", 64'(swap_s), 64'd4);
    chk("u_valid", 64'(out_valid_u), 64'd1);
    chk("u_data", 64'(out_data_u), 64'hEC61);
    chk("u_swap", 64'(swap_u), 64'd4);
    pop4();
    chk("idle_retain", 64'(out_data_s), 64'h61EC);

    // already sorted
    push4(16'h4321);
    wait_out4(lat);
    chk("sorted_lat", 64'(lat), 64'(LAT_SORTED));
    chk("sorted_data", 64'(out_data_s), 64'h4321);
    chk("sorted_swap", 64'(swap_s), 64'd0);
    pop4();

    // reverse order with backpressure; in_valid presented while busy
    push4(16'h1357);
    wait_out4(lat);
    chk("rev_lat", 64'(lat), 64'd10);
    in_data4  = 16'hABCD;
    in_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid_s), 64'd1);
      chk("hold_data", 64'(out_data_s), 64'h7531);
      chk("hold_swap", 64'(swap_s), 64'd6);
      chk("hold_iready", 64'(in_ready_s), 64'd0);
    end
    in_valid4 = 1'b0;
    pop4();
    chk("rev_retain", 64'(out_data_s), 64'h7531);

    // reset during the third sort cycle
    push4(16'h4321);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_iready", 64'(in_ready_s), 64'd1);
    chk("mid_rst_ovalid", 64'(out_valid_s), 64'd0);
    chk("mid_rst_swap", 64'(swap_s), 64'd0);
    chk("mid_rst_busy", 64'(busy_s), 64'd0);
    rst_n = 1'b1;
    push4(16'h1CE6);
    wait_out4(lat);
    chk("post_rst_lat", 64'(lat), 64'd10);
    chk("post_rst_data", 64'(out_data_s), 64'h61EC);
    chk("post_rst_swap", 64'(swap_s), 64'd4);
    pop4();

    // N=8: hand-computed vector with extremes and duplicates
    run8(64'h007F0180FF00807F, 64'h7F7F010000FF8080, 11);
    // random vectors, some elements drawn from a small pool to force duplicates
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 5))
          0: v[k*8 +: 8] = 8'h80;
          1: v[k*8 +: 8] = 8'h7F;
          2: v[k*8 +: 8] = 8'h05;
          default: v[k*8 +: 8] = 8'($urandom);
        endcase
      end
      ref8(v, s, inv);
      run8(v, s, inv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
